// File: rtl/alu_multiciclo_if.sv
// Request/response bundle between the datapath controller and the multi-cycle ALU.
// The controller drives the master side; the ALU is the slave.
interface alu_multiciclo_if #(
  parameter int WIDTH = 8
);
  logic             iStart;
  logic [3:0]       ivInstruccion;
  logic [WIDTH-1:0] ivRegistroA;
  logic [WIDTH-1:0] ivRegistroB;
  logic [WIDTH-1:0] ovResultado;
  logic [WIDTH-1:0] ovResultadoAlto;
  logic [3:0]       ovFlags;
  logic             oBusy;
  logic             oDone;

  modport master (
    output iStart, ivInstruccion, ivRegistroA, ivRegistroB,
    input  ovResultado, ovResultadoAlto, ovFlags, oBusy, oDone
  );

  modport slave (
    input  iStart, ivInstruccion, ivRegistroA, ivRegistroB,
    output ovResultado, ovResultadoAlto, ovFlags, oBusy, oDone
  );
endinterface

// File: rtl/alu_multiciclo.sv
// Registered ALU with start/done handshake, persistent {Z,N,C,V} flags,
// carry-chained ADC/SBC and WIDTH-iteration unsigned MUL (shift-add) / DIV (restoring).
module alu_multiciclo #(
  parameter int WIDTH = 8
) (
  input logic              iClk,
  input logic              iReset,
  alu_multiciclo_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100, OP_NAND = 4'b0101, OP_NOR  = 4'b0110, OP_XNOR = 4'b0111,
    OP_NOT  = 4'b1000, OP_LSH  = 4'b1001, OP_RSH  = 4'b1010, OP_ADC  = 4'b1011,
    OP_SBC  = 4'b1100, OP_MUL  = 4'b1101, OP_DIV  = 4'b1110, OP_RSV  = 4'b1111
  } opcode_t;

  state_t           r_state, w_next_state;
  opcode_t          r_op;
  logic [WIDTH-1:0] r_b, r_acc, r_q;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_res, r_res_hi;
  logic [3:0]       r_flags;

  opcode_t          w_op_in;
  logic             w_multi;
  logic [WIDTH-1:0] w_a, w_b;
  logic             w_cprev;
  logic [WIDTH:0]   w_wide;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_n;
  logic [3:0]       w_flags;

  logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_acc_nx, w_q_nx;
  logic [3:0]       w_calc_flags;

  assign w_op_in = opcode_t'(bus.ivInstruccion);
  assign w_multi = (w_op_in == OP_MUL) || (w_op_in == OP_DIV);
  assign w_a     = bus.ivRegistroA;
  assign w_b     = bus.ivRegistroB;
  assign w_cprev = r_flags[1];

  // Single-cycle ops are evaluated straight from the operand inputs so the
  // result can be registered on the accepting edge itself.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    w_wide = '0;
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    unique case (w_op_in)
      OP_ADD, OP_ADC: begin
        w_wide = {1'b0, w_a} + {1'b0, w_b}
               + {{WIDTH{1'b0}}, (w_op_in == OP_ADC) & w_cprev};
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
        w_v    = (w_res[WIDTH-1] ^ w_a[WIDTH-1]) & (w_res[WIDTH-1] ^ w_b[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        w_wide = {1'b0, w_a} - {1'b0, w_b}
               - {{WIDTH{1'b0}}, (w_op_in == OP_SBC) & w_cprev};
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
        w_v    = (w_a[WIDTH-1] ^ w_b[WIDTH-1]) & (w_a[WIDTH-1] ^ w_res[WIDTH-1]);
      end
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_NAND: w_res = ~(w_a & w_b);
      OP_NOR:  w_res = ~(w_a | w_b);
      OP_XNOR: w_res = ~(w_a ^ w_b);
      OP_NOT:  w_res = ~w_a;
      OP_LSH:  w_res = (w_b >= WIDTH'(WIDTH)) ? '0 : (w_a << w_b);
      OP_RSH:  w_res = (w_b >= WIDTH'(WIDTH)) ? '0 : (w_a >> w_b);
      default: w_res = '0;
    endcase
  end

  assign w_n     = (w_op_in == OP_RSV) ? 1'b0 : w_res[WIDTH-1];
  assign w_flags = {(w_res == '0), w_n, w_c, w_v};

  // One iteration of shift-add multiply or restoring divide on {r_acc, r_q}.
  assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_div_shift = {r_acc, r_q[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ok    = w_div_shift >= {1'b0, r_b};

  always_comb begin
    w_acc_nx     = '0;
    w_q_nx       = '0;
    w_calc_flags = '0;
    if (r_op == OP_MUL) begin
      w_acc_nx     = w_mul_sum[WIDTH:1];
      w_q_nx       = {w_mul_sum[0], r_q[WIDTH-1:1]};
      w_calc_flags = {({w_acc_nx, w_q_nx} == '0), 1'b0, (w_acc_nx != '0), 1'b0};
    end else begin
      w_acc_nx     = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_q_nx       = {r_q[WIDTH-2:0], w_div_ok};
      w_calc_flags = {(w_q_nx == '0), 1'b0, 1'b0, (r_b == '0)};
    end
  end

  always_ff @(posedge iClk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (iReset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.iStart) w_next_state = w_multi ? S_CALC : S_DONE;
      S_CALC:  if (r_count == CW'(1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.oBusy = (r_state != S_IDLE);
    bus.oDone = (r_state == S_DONE);
  end

  always_ff @(posedge iClk) begin
    // NOTE: datapath registers are reset too, so an abandoned MUL/DIV leaves no stale partials or outputs.
    if (iReset) begin
      r_op     <= OP_ADD;
      r_b      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_count  <= '0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_flags  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.iStart) begin
          r_op    <= w_op_in;
          r_b     <= w_b;
          r_acc   <= '0;
          r_q     <= w_a;
          r_count <= CW'(WIDTH);
          if (!w_multi) begin
            r_res    <= w_res;
            r_res_hi <= '0;
            r_flags  <= w_flags;
          end
        end
        S_CALC: begin
          r_acc   <= w_acc_nx;
          r_q     <= w_q_nx;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_res    <= w_q_nx;
            r_res_hi <= w_acc_nx;
            r_flags  <= w_calc_flags;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ovResultado     = r_res;
  assign bus.ovResultadoAlto = r_res_hi;
  assign bus.ovFlags         = r_flags;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo at WIDTH=8: results, flags, latency,
// busy-time start rejection and mid-operation reset.
module tb_alu_multiciclo;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_multiciclo_if #(.WIDTH(W)) bus ();

  alu_multiciclo #(.WIDTH(W)) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op; latency counts cycles from the accepting edge to the oDone cycle.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat, input logic [7:0] exp_res,
                       input logic [7:0] exp_hi, input logic [3:0] exp_flags,
                       input bit poke_busy);
    int lat;
    int dones;
    @(negedge clk);
    bus.iStart        = 1'b1;
    bus.ivInstruccion = op;
    bus.ivRegistroA   = a;
    bus.ivRegistroB   = b;
    @(posedge clk);
    @(negedge clk);
    bus.iStart        = poke_busy;
    bus.ivInstruccion = 4'b0000;
    bus.ivRegistroA   = ~a;
    bus.ivRegistroB   = ~b;
    lat = 1;
    while (!bus.oDone && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bus.iStart = 1'b0;
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_res"},   bus.ovResultado, exp_res);
    check({tag, "_hi"},    bus.ovResultadoAlto, exp_hi);
    check({tag, "_flags"}, bus.ovFlags, exp_flags);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.oDone) dones++;
    end
    check({tag, "_extra_done"}, dones, 0);
    check({tag, "_idle"}, bus.oBusy, 1'b0);
    check({tag, "_hold"}, bus.ovResultado, exp_res);
  endtask

  initial begin
    int dones;
    bus.iStart        = 1'b0;
    bus.ivInstruccion = '0;
    bus.ivRegistroA   = '0;
    bus.ivRegistroB   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_res",   bus.ovResultado, 8'h00);
    check("rst_hi",    bus.ovResultadoAlto, 8'h00);
    check("rst_flags", bus.ovFlags, 4'h0);
    check("rst_busy",  bus.oBusy, 1'b0);
    check("rst_done",  bus.oDone, 1'b0);

    do_op("add_ovf",  4'b0000, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 4'b0101, 1'b0);
    do_op("sub_brw",  4'b0001, 8'h00, 8'h01, 1, 8'hFF, 8'h00, 4'b0110, 1'b0);
    do_op("sbc",      4'b1100, 8'h10, 8'h05, 1, 8'h0A, 8'h00, 4'b0000, 1'b0);
    do_op("add_zc",   4'b0000, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 4'b1010, 1'b0);
    do_op("adc",      4'b1011, 8'h01, 8'h01, 1, 8'h03, 8'h00, 4'b0000, 1'b0);
    do_op("and",      4'b0010, 8'hF0, 8'h3C, 1, 8'h30, 8'h00, 4'b0000, 1'b0);
    do_op("xor",      4'b0100, 8'hAA, 8'h55, 1, 8'hFF, 8'h00, 4'b0100, 1'b0);
    do_op("nand",     4'b0101, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 4'b1000, 1'b0);
    do_op("not",      4'b1000, 8'h0F, 8'h00, 1, 8'hF0, 8'h00, 4'b0100, 1'b0);
    do_op("lsh_big",  4'b1001, 8'h81, 8'h09, 1, 8'h00, 8'h00, 4'b1000, 1'b0);
    do_op("rsh",      4'b1010, 8'h80, 8'h07, 1, 8'h01, 8'h00, 4'b0000, 1'b0);
    do_op("mul_max",  4'b1101, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 4'b0010, 1'b1);
    do_op("mul_256",  4'b1101, 8'h10, 8'h10, 9, 8'h00, 8'h01, 4'b0010, 1'b0);
    do_op("mul_zero", 4'b1101, 8'h00, 8'h05, 9, 8'h00, 8'h00, 4'b1000, 1'b0);
    do_op("rsv",      4'b1111, 8'h12, 8'h34, 1, 8'h00, 8'h00, 4'b1000, 1'b0);
    do_op("div",      4'b1110, 8'd100, 8'd7, 9, 8'h0E, 8'h02, 4'b0000, 1'b0);
    do_op("div_ff",   4'b1110, 8'hFF, 8'h10, 9, 8'h0F, 8'h0F, 4'b0000, 1'b0);
    do_op("div_zero", 4'b1110, 8'h2A, 8'h00, 9, 8'hFF, 8'h2A, 4'b0001, 1'b0);

    // Reset during MUL: start accepted at edge k, reset sampled at the end of cycle k+4.
    @(negedge clk);
    bus.iStart        = 1'b1;
    bus.ivInstruccion = 4'b1101;
    bus.ivRegistroA   = 8'hFF;
    bus.ivRegistroB   = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.iStart = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_busy_before", bus.oBusy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",  bus.oBusy, 1'b0);
    check("mrst_done",  bus.oDone, 1'b0);
    check("mrst_res",   bus.ovResultado, 8'h00);
    check("mrst_hi",    bus.ovResultadoAlto, 8'h00);
    check("mrst_flags", bus.ovFlags, 4'h0);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.oDone) dones++;
    end
    check("mrst_no_done", dones, 0);
    do_op("add_after_rst", 4'b0000, 8'h01, 8'h01, 1, 8'h02, 8'h00, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
